// File: rtl/sysbus_arbiter.sv
// sysbus_arbiter: round-robin sharing of the single Sysbus master port between
// port 0 (instruction fetch) and port 1 (data access). One transaction is in
// flight at a time. The winner's address/tag is registered onto the bus and held
// until bus_reqack. The BEATS-long response burst is then routed back to the owner.
module sysbus_arbiter #(
    parameter int BUS_DATA_WIDTH = 64,
    parameter int BUS_TAG_WIDTH  = 13,
    parameter int BEATS          = 8
) (
    input  logic                      clk,
    input  logic                      reset,

    input  logic                      m0_req,
    input  logic [BUS_DATA_WIDTH-1:0] m0_addr,
    input  logic [BUS_TAG_WIDTH-1:0]  m0_tag,
    output logic                      m0_gnt,
    output logic                      m0_rvalid,
    output logic [BUS_DATA_WIDTH-1:0] m0_rdata,
    output logic                      m0_rlast,

    input  logic                      m1_req,
    input  logic [BUS_DATA_WIDTH-1:0] m1_addr,
    input  logic [BUS_TAG_WIDTH-1:0]  m1_tag,
    output logic                      m1_gnt,
    output logic                      m1_rvalid,
    output logic [BUS_DATA_WIDTH-1:0] m1_rdata,
    output logic                      m1_rlast,

    output logic                      bus_reqcyc,
    output logic [BUS_DATA_WIDTH-1:0] bus_req,
    output logic [BUS_TAG_WIDTH-1:0]  bus_reqtag,
    input  logic                      bus_reqack,
    input  logic                      bus_respcyc,
    input  logic [BUS_DATA_WIDTH-1:0] bus_resp,
    input  logic [BUS_TAG_WIDTH-1:0]  bus_resptag,
    output logic                      bus_respack
);

    localparam int CW = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam logic [CW-1:0] LAST_BEAT = CW'(BEATS - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t                    state_q, state_d;
    logic                      rr_last_q, rr_last_d;   // port that won most recently
    logic                      owner_q, owner_d;       // port owning the transaction in flight
    logic [CW-1:0]             beat_cnt_q, beat_cnt_d;
    logic                      reqcyc_q, reqcyc_d;
    logic [BUS_DATA_WIDTH-1:0] req_addr_q, req_addr_d;
    logic [BUS_TAG_WIDTH-1:0]  req_tag_q, req_tag_d;

    logic                      winner;
    logic                      gnt_hit;
    logic                      beat_hit;
    logic                      last_hit;

    // Routing ignores the response tag; only one transaction is ever outstanding.
    logic unused_resptag;
    assign unused_resptag = ^bus_resptag;

    // Next-state, bus register and requester-side strobe logic.
    always_comb begin
        // NOTE: every signal gets a default before the case so no path leaves one unassigned (no latches).
        state_d     = state_q;
        rr_last_d   = rr_last_q;
        owner_d     = owner_q;
        beat_cnt_d  = beat_cnt_q;
        reqcyc_d    = reqcyc_q;
        req_addr_d  = req_addr_q;
        req_tag_d   = req_tag_q;
        winner      = 1'b0;
        gnt_hit     = 1'b0;
        beat_hit    = 1'b0;
        last_hit    = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (m0_req || m1_req) begin
                    // Tie goes to the port that did not win last; otherwise the sole requester.
                    winner     = (m0_req && m1_req) ? ~rr_last_q : m1_req;
                    state_d    = REQ;
                    owner_d    = winner;
                    rr_last_d  = winner;
                    reqcyc_d   = 1'b1;
                    req_addr_d = winner ? m1_addr : m0_addr;
                    req_tag_d  = winner ? m1_tag : m0_tag;
                end
            end
            REQ: begin
                // A response beat coinciding with the ack is not ours yet and is ignored.
                if (bus_reqack) begin
                    gnt_hit    = 1'b1;
                    reqcyc_d   = 1'b0;
                    beat_cnt_d = '0;
                    state_d    = RESP;
                end
            end
            RESP: begin
                beat_hit = bus_respcyc;
                last_hit = bus_respcyc && (beat_cnt_q == LAST_BEAT);
                if (last_hit) begin
                    beat_cnt_d = '0;
                    state_d    = IDLE;
                end else if (beat_hit) begin
                    beat_cnt_d = beat_cnt_q + CW'(1);
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Requester-facing strobes and response data steered by the current owner.
    always_comb begin
        m0_gnt      = gnt_hit & ~owner_q;
        m1_gnt      = gnt_hit & owner_q;
        m0_rvalid   = beat_hit & ~owner_q;
        m1_rvalid   = beat_hit & owner_q;
        m0_rlast    = last_hit & ~owner_q;
        m1_rlast    = last_hit & owner_q;
        m0_rdata    = (state_q == RESP && !owner_q) ? bus_resp : '0;
        m1_rdata    = (state_q == RESP && owner_q) ? bus_resp : '0;
        bus_respack = beat_hit;
        bus_reqcyc  = reqcyc_q;
        bus_req     = req_addr_q;
        bus_reqtag  = req_tag_q;
    end

    // State register; reset aborts any transaction in flight.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= IDLE;
            rr_last_q  <= 1'b1;
            owner_q    <= 1'b0;
            beat_cnt_q <= '0;
            reqcyc_q   <= 1'b0;
            req_addr_q <= '0;
            req_tag_q  <= '0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so all registers update together.
            state_q    <= state_d;
            rr_last_q  <= rr_last_d;
            owner_q    <= owner_d;
            beat_cnt_q <= beat_cnt_d;
            reqcyc_q   <= reqcyc_d;
            req_addr_q <= req_addr_d;
            req_tag_q  <= req_tag_d;
        end
    end

endmodule

// File: tb/tb_sysbus_arbiter.sv
// tb_sysbus_arbiter: directed scenarios followed by randomized traffic.
// Expected grant order comes from the round-robin rule applied to the request
// levels. Expected beats come from the data the bench itself puts on the bus.
module tb_sysbus_arbiter;

    localparam int DW    = 64;
    localparam int TW    = 13;
    localparam int BEATS = 8;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic          m0_req = 1'b0, m1_req = 1'b0;
    logic [DW-1:0] m0_addr = '0, m1_addr = '0;
    logic [TW-1:0] m0_tag = '0, m1_tag = '0;
    logic          m0_gnt, m1_gnt, m0_rvalid, m1_rvalid, m0_rlast, m1_rlast;
    logic [DW-1:0] m0_rdata, m1_rdata;
    logic          bus_reqcyc;
    logic [DW-1:0] bus_req;
    logic [TW-1:0] bus_reqtag;
    logic          bus_reqack = 1'b0;
    logic          bus_respcyc = 1'b0;
    logic [DW-1:0] bus_resp = '0;
    logic [TW-1:0] bus_resptag = '0;
    logic          bus_respack;

    int n_checks = 0;
    int n_err    = 0;
    int model_last = 1;       // port that won the most recent arbitration
    logic [DW-1:0] a0, a1;
    logic [TW-1:0] t0, t1;

    sysbus_arbiter #(.BUS_DATA_WIDTH(DW), .BUS_TAG_WIDTH(TW), .BEATS(BEATS)) dut (
        .clk(clk), .reset(reset),
        .m0_req(m0_req), .m0_addr(m0_addr), .m0_tag(m0_tag), .m0_gnt(m0_gnt),
        .m0_rvalid(m0_rvalid), .m0_rdata(m0_rdata), .m0_rlast(m0_rlast),
        .m1_req(m1_req), .m1_addr(m1_addr), .m1_tag(m1_tag), .m1_gnt(m1_gnt),
        .m1_rvalid(m1_rvalid), .m1_rdata(m1_rdata), .m1_rlast(m1_rlast),
        .bus_reqcyc(bus_reqcyc), .bus_req(bus_req), .bus_reqtag(bus_reqtag),
        .bus_reqack(bus_reqack), .bus_respcyc(bus_respcyc), .bus_resp(bus_resp),
        .bus_resptag(bus_resptag), .bus_respack(bus_respack)
    );

    always #5 clk = ~clk;

    initial begin
        #400000;
        $display("FAIL watchdog: observed=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Round-robin rule: a sole requester wins; on a tie the port that did not win last.
    function automatic int pick(input bit r0, input bit r1);
        if (r0 && r1) return 1 - model_last;
        return r1 ? 1 : 0;
    endfunction

    task automatic raise(input int p);
        if (p == 0) begin
            a0 = {$urandom, $urandom};
            t0 = TW'($urandom_range(0, 8191));
            m0_addr = a0; m0_tag = t0; m0_req = 1'b1;
        end else begin
            a1 = {$urandom, $urandom};
            t1 = TW'($urandom_range(0, 8191));
            m1_addr = a1; m1_tag = t1; m1_req = 1'b1;
        end
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_reqcyc"}, bus_reqcyc, 0);
        check({tag, "_req"}, bus_req, 0);
        check({tag, "_reqtag"}, bus_reqtag, 0);
        check({tag, "_gnt"}, {m0_gnt, m1_gnt}, 0);
        check({tag, "_rvalid"}, {m0_rvalid, m1_rvalid}, 0);
        check({tag, "_rlast"}, {m0_rlast, m1_rlast}, 0);
        check({tag, "_rdata0"}, m0_rdata, 0);
        check({tag, "_respack"}, bus_respack, 0);
    endtask

    // One full transaction, started while the DUT is idle with requests already visible.
    // rb0/rb1: beat index at which that port raises a fresh request (out of range = never).
    // abort_beat: beat at which reset is pulled low instead of delivering the beat.
    task automatic run_txn(input string tag, input int rb0, input int rb1, input int ack_delay,
                           input int gaps, input logic [63:0] base, input int abort_beat);
        int w;
        int cyc;
        logic [DW-1:0] exp_addr;
        logic [TW-1:0] exp_tag;
        w = pick(m0_req, m1_req);
        cyc = 0;
        while (!bus_reqcyc && cyc < 6) begin
            check({tag, "_pregnt"}, {m0_gnt, m1_gnt}, 0);
            step();
            cyc++;
        end
        check({tag, "_reqcyc_seen"}, bus_reqcyc, 1);
        if (!bus_reqcyc) return;
        model_last = w;
        exp_addr = (w == 1) ? a1 : a0;
        exp_tag  = (w == 1) ? t1 : t0;
        for (int i = 0; i < ack_delay; i++) begin
            check({tag, "_hold_req"}, bus_req, exp_addr);
            check({tag, "_hold_gnt"}, {m0_gnt, m1_gnt}, 0);
            step();
        end
        bus_reqack = 1'b1;
        #1;
        check({tag, "_req"}, bus_req, exp_addr);
        check({tag, "_reqtag"}, bus_reqtag, exp_tag);
        check({tag, "_gnt"}, {m1_gnt, m0_gnt}, (w == 1) ? 2'b10 : 2'b01);
        step();
        bus_reqack = 1'b0;
        if (w == 0) m0_req = 1'b0; else m1_req = 1'b0;
        #1;
        check({tag, "_reqcyc_drop"}, bus_reqcyc, 0);
        for (int b = 0; b < BEATS; b++) begin
            if (b == rb0 && !m0_req) raise(0);
            if (b == rb1 && !m1_req) raise(1);
            for (int g = 0; g < gaps; g++) begin
                #1;
                check({tag, "_gap"}, {m0_rvalid, m1_rvalid, bus_respack}, 0);
                step();
            end
            bus_respcyc = 1'b1;
            bus_resp = base + 64'(b);
            if (b == abort_beat) begin
                reset = 1'b0;
                #1;
                check_all_zero({tag, "_abort"});
                return;
            end
            #1;
            check({tag, "_rvalid"}, {m1_rvalid, m0_rvalid}, (w == 1) ? 2'b10 : 2'b01);
            check({tag, "_rdata"}, (w == 1) ? m1_rdata : m0_rdata, base + 64'(b));
            check({tag, "_other_rdata"}, (w == 1) ? m0_rdata : m1_rdata, 0);
            check({tag, "_rlast"}, {m0_rlast | m1_rlast}, (b == BEATS - 1));
            check({tag, "_respack"}, bus_respack, 1);
            step();
            bus_respcyc = 1'b0;
        end
    endtask

    initial begin
        // Reset state.
        step(); step();
        check_all_zero("reset");
        reset = 1'b1;
        step();

        // T1: port 0 alone, fixed address/tag, ack on the third request cycle.
        a0 = 64'h1000; t0 = 13'h1100;
        m0_addr = a0; m0_tag = t0; m0_req = 1'b1;
        run_txn("t1", -1, -1, 2, 0, 64'hA0, -1);

        // T6: response strobe while idle is ignored.
        bus_respcyc = 1'b1;
        bus_resp = 64'hDEAD;
        #1;
        check("t6_respack", bus_respack, 0);
        check("t6_rvalid", {m0_rvalid, m1_rvalid}, 0);
        step(); step();
        check("t6_idle", bus_reqcyc, 0);
        bus_respcyc = 1'b0;

        // T2: both request together out of reset; alternate 0,1,0,1.
        reset = 1'b0;
        step();
        reset = 1'b1;
        model_last = 1;
        raise(0); raise(1);
        run_txn("t2a", 2, -1, 0, 0, {$urandom, $urandom}, -1);
        run_txn("t2b", -1, 3, 1, 0, {$urandom, $urandom}, -1);
        run_txn("t2c", -1, -1, 0, 0, {$urandom, $urandom}, -1);
        run_txn("t2d", -1, -1, 0, 0, {$urandom, $urandom}, -1);

        // T3: port 1 keeps requesting, port 0 appears mid-burst and goes next.
        raise(1);
        run_txn("t3a", 2, 0, 0, 0, {$urandom, $urandom}, -1);
        run_txn("t3b", -1, -1, 0, 0, {$urandom, $urandom}, -1);
        run_txn("t3c", -1, -1, 0, 0, {$urandom, $urandom}, -1);

        // T4: two idle cycles between every beat.
        raise(0);
        run_txn("t4", -1, -1, 1, 2, {$urandom, $urandom}, -1);

        // T5: reset during beat 4, then a clean burst.
        raise(0);
        run_txn("t5a", -1, -1, 0, 0, {$urandom, $urandom}, 4);
        m0_req = 1'b0; m1_req = 1'b0;
        step();
        bus_respcyc = 1'b0;
        reset = 1'b1;
        model_last = 1;
        raise(1);
        run_txn("t5b", -1, -1, 0, 0, {$urandom, $urandom}, -1);

        // Randomized traffic.
        for (int r = 0; r < 30; r++) begin
            int sel;
            if (!m0_req && !m1_req) begin
                sel = $urandom_range(1, 3);
                if (sel[0]) raise(0);
                if (sel[1]) raise(1);
            end
            run_txn("rnd", $urandom_range(0, 11) - 3, $urandom_range(0, 11) - 3,
                    $urandom_range(0, 3), $urandom_range(0, 2), {$urandom, $urandom}, -1);
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
